neosd_dat_rx: RTL and testbench

NEOSD_DAT_RX -- requirements
Module: neosd_dat_rx

---
 rtl/neosd_dat_rx.sv | 196 +++++++++++++++++++
 tb/tb_neosd_dat_rx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/neosd_dat_rx.sv
// neosd_dat_rx: SD-card DAT0 single-line block receiver.
// Waits for a start bit, shifts BLK_BYTES bytes MSB first into a small
// output FIFO while running CRC16-CCITT, then checks the received CRC
// and the end bit. Errors are sticky until the next start.
module neosd_dat_rx #(
    parameter int BLK_BYTES  = 512,
    parameter int TIMEOUT    = 65535,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       sd_dat0_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] err_o
);

    localparam int BCW = $clog2(BLK_BYTES + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END_BIT
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       bit_q, bit_d;
    logic [3:0]       cbit_q, cbit_d;
    logic [BCW-1:0]   byte_q, byte_d;
    logic [15:0]      tmo_q, tmo_d, tmo_inc;
    logic [15:0]      crc_q, crc_d, crc_nx;
    // Received CRC keeps 15 bits; the 16th is the live sample at compare time.
    logic [14:0]      rxcrc_q, rxcrc_d;
    // Only 7 bits are stored; the 8th bit goes straight into the FIFO.
    logic [6:0]       sh_q, sh_d;
    logic [3:0]       err_q, err_d;
    logic             done_q, done_d;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic             empty, full, pop, push, wr_en, flush;
    logic [7:0]       push_byte;

    assign empty     = (wr_q == rd_q);
    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop       = !empty && ready_i;
    assign push_byte = {sh_q, sd_dat0_i};
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en     = push && (!full || pop);
    assign tmo_inc   = tmo_q + 16'd1;
    assign crc_nx    = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ sd_dat0_i) ? 16'h1021 : 16'h0000);

    assign data_o  = empty ? 8'h00 : mem[rd_q[AW-1:0]];
    assign valid_o = !empty;
    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = done_q;
    assign err_o   = err_q;

    // Next-state, datapath and FIFO-pointer logic.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        cbit_d  = cbit_q;
        byte_d  = byte_q;
        tmo_d   = tmo_q;
        crc_d   = crc_q;
        rxcrc_d = rxcrc_q;
        sh_d    = sh_q;
        err_d   = err_q;
        done_d  = 1'b0;
        push    = 1'b0;
        flush   = 1'b0;
        if (abort_i) begin
            state_d = S_IDLE;
            flush   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = S_WAIT_START;
                        err_d   = 4'b0000;
                        flush   = 1'b1;
                        crc_d   = 16'h0000;
                        tmo_d   = 16'h0000;
                        bit_d   = 3'd0;
                        byte_d  = '0;
                        cbit_d  = 4'd0;
                    end
                end
                S_WAIT_START: begin
                    if (tick_i) begin
                        if (!sd_dat0_i) begin
                            state_d = S_DATA;
                            bit_d   = 3'd0;
                            byte_d  = '0;
                        end else begin
                            tmo_d = tmo_inc;
                            if (tmo_inc == 16'(TIMEOUT)) begin
                                err_d[1] = 1'b1;
                                done_d   = 1'b1;
                                state_d  = S_IDLE;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (tick_i) begin
                        sh_d  = {sh_q[5:0], sd_dat0_i};
                        crc_d = crc_nx;
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            push   = 1'b1;
                            byte_d = byte_q + BCW'(1);
                            if (byte_q == BCW'(BLK_BYTES - 1)) begin
                                state_d = S_CRC;
                                cbit_d  = 4'd0;
                            end
                        end
                    end
                end
                S_CRC: begin
                    if (tick_i) begin
                        rxcrc_d = {rxcrc_q[13:0], sd_dat0_i};
                        cbit_d  = cbit_q + 4'd1;
                        if (cbit_q == 4'd15) begin
                            state_d = S_END_BIT;
                            if ({rxcrc_q, sd_dat0_i} != crc_q) err_d[0] = 1'b1;
                        end
                    end
                end
                S_END_BIT: begin
                    if (tick_i) begin
                        if (!sd_dat0_i) err_d[3] = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (push && full && !pop) err_d[2] = 1'b1;

        wr_d = wr_q;
        rd_d = rd_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (pop)   rd_d = rd_q + PW'(1);
            if (wr_en) wr_d = wr_q + PW'(1);
        end
    end

    // State and control registers; reset overrides every other input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            bit_q   <= 3'd0;
            cbit_q  <= 4'd0;
            byte_q  <= '0;
            tmo_q   <= 16'h0000;
            crc_q   <= 16'h0000;
            rxcrc_q <= 15'h0000;
            sh_q    <= 7'h00;
            err_q   <= 4'b0000;
            done_q  <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            cbit_q  <= cbit_d;
            byte_q  <= byte_d;
            tmo_q   <= tmo_d;
            crc_q   <= crc_d;
            rxcrc_q <= rxcrc_d;
            sh_q    <= sh_d;
            err_q   <= err_d;
            done_q  <= done_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    // FIFO storage; contents are masked on data_o while empty, so no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_q[AW-1:0]] <= push_byte;
    end

endmodule

// File: tb/tb_neosd_dat_rx.sv
// Testbench for neosd_dat_rx: two instances (512-byte and 8-byte blocks)
// share tick/DAT0/reset; per-instance queues hold expected bytes and the
// expected err_o at each done_o pulse, checked by a negedge monitor.
module tb_neosd_dat_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0, dat = 1'b1;
    logic start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b1;
    logic start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic valid_a, valid_b, busy_a, busy_b, done_a, done_b;
    logic [3:0] err_a, err_b;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [7:0] expa[$], expb[$];
    logic [3:0] erra_q[$], errb_q[$];

    always #5 clk = ~clk;

    neosd_dat_rx #(.BLK_BYTES(512), .TIMEOUT(65535), .FIFO_DEPTH(4)) u_a (
        .clk_i(clk), .rst_i(rst), .tick_i(tick), .start_i(start_a), .abort_i(abort_a),
        .sd_dat0_i(dat), .data_o(data_a), .valid_o(valid_a), .ready_i(ready_a),
        .busy_o(busy_a), .done_o(done_a), .err_o(err_a));

    neosd_dat_rx #(.BLK_BYTES(8), .TIMEOUT(16), .FIFO_DEPTH(4)) u_b (
        .clk_i(clk), .rst_i(rst), .tick_i(tick), .start_i(start_b), .abort_i(abort_b),
        .sd_dat0_i(dat), .data_o(data_b), .valid_o(valid_b), .ready_i(ready_b),
        .busy_o(busy_b), .done_o(done_b), .err_o(err_b));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic note_fail(input string nm, input logic [31:0] act);
        total_cnt++;
        $display("FAIL %s: got %0h expected nothing", nm, act);
    endtask

    // Monitor: output bytes and done pulses against the scoreboard queues.
    always @(negedge clk) begin
        if (valid_a && ready_a) begin
            if (expa.size() == 0) note_fail("a_extra_byte", 32'(data_a));
            else chk("a_data", 32'(data_a), 32'(expa.pop_front()));
        end
        if (valid_b && ready_b) begin
            if (expb.size() == 0) note_fail("b_extra_byte", 32'(data_b));
            else chk("b_data", 32'(data_b), 32'(expb.pop_front()));
        end
        if (done_a) begin
            if (erra_q.size() == 0) note_fail("a_unexpected_done", 32'(err_a));
            else chk("a_done_err", 32'(err_a), 32'(erra_q.pop_front()));
        end
        if (done_b) begin
            if (errb_q.size() == 0) note_fail("b_unexpected_done", 32'(err_b));
            else chk("b_done_err", 32'(err_b), 32'(errb_q.pop_front()));
        end
    end

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        logic fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ b[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        dat  = b;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
    endtask

    initial begin
        logic [15:0] crc;
        logic [7:0]  blk [8];
        logic [7:0]  mid;

        // Reset state
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk("rst_busy", 32'(busy_b), 0);
        chk("rst_valid", 32'(valid_b), 0);
        chk("rst_data", 32'(data_b), 0);
        chk("rst_err", 32'(err_b), 0);
        chk("rst_done", 32'(done_a), 0);

        // 512 x 0xFF, correct CRC, good end bit
        start_a = 1'b1; cyc(); start_a = 1'b0;
        chk("a_busy_after_start", 32'(busy_a), 1);
        send_bit(1'b0);
        for (int i = 0; i < 512; i++) begin
            expa.push_back(8'hFF);
            send_byte(8'hFF);
        end
        send_word(16'h7FA1);
        chk("a_busy_end_state", 32'(busy_a), 1);
        erra_q.push_back(4'b0000);
        send_bit(1'b1);
        repeat (4) cyc();
        chk("a_all_bytes_out", 32'(expa.size()), 0);
        chk("a_done_seen", 32'(erra_q.size()), 0);
        chk("a_idle", 32'(busy_a), 0);

        // Same block with a wrong CRC
        start_a = 1'b1; cyc(); start_a = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 512; i++) begin
            expa.push_back(8'hFF);
            send_byte(8'hFF);
        end
        send_word(16'h7FA0);
        erra_q.push_back(4'b0001);
        send_bit(1'b1);
        repeat (4) cyc();
        chk("a_crcerr_bytes_out", 32'(expa.size()), 0);
        chk("a_crcerr_done_seen", 32'(erra_q.size()), 0);

        // Timeout: DAT0 held high for TIMEOUT=16 ticks
        start_b = 1'b1; cyc(); start_b = 1'b0;
        errb_q.push_back(4'b0010);
        repeat (15) send_bit(1'b1);
        chk("b_busy_tick15", 32'(busy_b), 1);
        send_bit(1'b1);
        chk("b_busy_after_timeout", 32'(busy_b), 0);
        chk("b_timeout_err_sticky", 32'(err_b), 32'h2);
        chk("b_timeout_done_seen", 32'(errb_q.size()), 0);

        // Overrun with consumer stalled, then bad end bit
        ready_b = 1'b0;
        start_b = 1'b1; cyc(); start_b = 1'b0;
        send_bit(1'b0);
        crc = 16'h0000;
        for (int i = 1; i <= 8; i++) begin
            if (i <= 4) expb.push_back(8'(i));
            crc = crc_byte(crc, 8'(i));
            send_byte(8'(i));
        end
        send_word(crc);
        chk("b_overrun_err", 32'(err_b), 32'h4);
        chk("b_fifo_head", 32'(data_b), 32'h01);
        errb_q.push_back(4'b1100);
        send_bit(1'b0);
        repeat (2) cyc();
        chk("b_ovr_done_seen", 32'(errb_q.size()), 0);
        chk("b_fifo_held", 32'(expb.size()), 4);
        ready_b = 1'b1;
        repeat (6) cyc();
        chk("b_drained", 32'(expb.size()), 0);
        chk("b_empty_after_drain", 32'(valid_b), 0);

        // Abort beats start in the same cycle
        start_b = 1'b1; abort_b = 1'b1; cyc(); start_b = 1'b0; abort_b = 1'b0;
        chk("b_abort_wins", 32'(busy_b), 0);

        // Abort during byte 3, then a clean block
        start_b = 1'b1; cyc(); start_b = 1'b0;
        send_bit(1'b0);
        expb.push_back(8'h11); send_byte(8'h11);
        expb.push_back(8'h22); send_byte(8'h22);
        expb.push_back(8'h33); send_byte(8'h33);
        mid = 8'h44;
        for (int i = 7; i >= 4; i--) send_bit(mid[i]);
        abort_b = 1'b1; cyc(); abort_b = 1'b0;
        chk("b_abort_idle", 32'(busy_b), 0);
        chk("b_abort_valid", 32'(valid_b), 0);
        chk("b_abort_err", 32'(err_b), 0);
        repeat (4) cyc();
        blk = '{8'hA5, 8'h3C, 8'h00, 8'hFF, 8'h5A, 8'hC3, 8'h81, 8'h7E};
        start_b = 1'b1; cyc(); start_b = 1'b0;
        send_bit(1'b0);
        crc = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            expb.push_back(blk[i]);
            crc = crc_byte(crc, blk[i]);
            send_byte(blk[i]);
        end
        send_word(crc);
        errb_q.push_back(4'b0000);
        send_bit(1'b1);
        repeat (4) cyc();
        chk("b_clean_bytes_out", 32'(expb.size()), 0);
        chk("b_clean_done_seen", 32'(errb_q.size()), 0);

        // Reset in the middle of DATA with a full FIFO and overrun flagged
        ready_b = 1'b0;
        start_b = 1'b1; cyc(); start_b = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 6; i++) send_byte(8'h60 + 8'(i));
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        chk("b_pre_rst_valid", 32'(valid_b), 1);
        chk("b_pre_rst_err", 32'(err_b), 32'h4);
        dat = 1'b0; tick = 1'b1; start_b = 1'b1; abort_b = 1'b1; rst = 1'b1;
        cyc();
        rst = 1'b0; tick = 1'b0; start_b = 1'b0; abort_b = 1'b0; dat = 1'b1;
        chk("b_rst_busy", 32'(busy_b), 0);
        chk("b_rst_valid", 32'(valid_b), 0);
        chk("b_rst_data", 32'(data_b), 0);
        chk("b_rst_err", 32'(err_b), 0);
        chk("b_rst_done", 32'(done_b), 0);
        chk("a_rst_err", 32'(err_a), 0);
        ready_b = 1'b1;
        repeat (4) cyc();
        chk("b_rst_no_output", 32'(valid_b), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
